// File: rtl/bow_prbs_dbi_gen.sv
// BoW PRBS7/15/23/31 word generator with valid/ready output and optional DBI encoding.
// Define BOW_PRBS_DBI_EN to enable DBI; otherwise out_data is the raw word and out_dbi is 0.
module bow_prbs_dbi_gen #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [30:0]      seed,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_dbi,
    output logic [CNT_W-1:0] word_count
);

    logic [1:0]       mode_q, mode_d;
    logic [30:0]      s_q, s_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_dbi_q, out_dbi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       src_mode;
    logic [30:0]      src_s;
    logic [30:0]      s_next;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] enc;
    logic             enc_dbi;
    logic             xfer;
    logic             advance;

    function automatic logic [30:0] seed_mask(input logic [1:0] m, input logic [30:0] sd);
        logic [30:0] v;
        case (m)
            2'b00:   v = {24'b0, sd[6:0]};
            2'b01:   v = {16'b0, sd[14:0]};
            2'b10:   v = {8'b0, sd[22:0]};
            default: v = sd;
        endcase
        // an all-zero LFSR would never leave the zero state
        if (v == 31'd0) v = 31'd1;
        return v;
    endfunction

    function automatic logic lfsr_fb(input logic [1:0] m, input logic [30:0] s);
        logic fb;
        case (m)
            2'b00:   fb = s[6] ^ s[5];
            2'b01:   fb = s[14] ^ s[13];
            2'b10:   fb = s[22] ^ s[17];
            default: fb = s[30] ^ s[27];
        endcase
        return fb;
    endfunction

    function automatic logic [30:0] lfsr_shift(input logic [1:0] m, input logic [30:0] s,
                                               input logic fb);
        logic [30:0] v;
        case (m)
            2'b00:   v = {24'b0, s[5:0], fb};
            2'b01:   v = {16'b0, s[13:0], fb};
            2'b10:   v = {8'b0, s[21:0], fb};
            default: v = {s[29:0], fb};
        endcase
        return v;
    endfunction

    // WIDTH LFSR steps unrolled; the first generated bit lands in the MSB
    function automatic logic [WIDTH+30:0] unroll(input logic [1:0] m, input logic [30:0] s0);
        logic [30:0]      s;
        logic [WIDTH-1:0] w;
        logic             fb;
        s = s0;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fb = lfsr_fb(m, s);
            w  = {w[WIDTH-2:0], fb};
            s  = lfsr_shift(m, s, fb);
        end
        return {w, s};
    endfunction

    always_comb begin
        src_mode      = seed_load ? mode : mode_q;
        src_s         = seed_load ? seed_mask(mode, seed) : s_q;
        {raw, s_next} = unroll(src_mode, src_s);
    end

`ifdef BOW_PRBS_DBI_EN
    localparam int PCW = $clog2(WIDTH + 1);

    function automatic logic [PCW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + PCW'(v[i]);
        return c;
    endfunction

    // out_data_q is the word last driven on the wire; a seed load restarts from 0
    logic [WIDTH-1:0] prev;
    logic [PCW-1:0]   toggles;

    always_comb begin
        prev    = seed_load ? '0 : out_data_q;
        toggles = popcount(raw ^ prev);
        enc_dbi = (toggles > PCW'(WIDTH / 2));
        enc     = enc_dbi ? ~raw : raw;
    end
`else
    always_comb begin
        enc     = raw;
        enc_dbi = 1'b0;
    end
`endif

    always_comb begin
        xfer        = out_valid_q & out_ready;
        advance     = seed_load | ~out_valid_q | out_ready;
        mode_d      = mode_q;
        s_d         = s_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_dbi_d   = out_dbi_q;
        cnt_d       = cnt_q;

        if (seed_load) mode_d = mode;
        if (advance) begin
            s_d         = s_next;
            out_valid_d = 1'b1;
            out_data_d  = enc;
            out_dbi_d   = enc_dbi;
        end

        if (seed_load)
            cnt_d = '0;
        else if (xfer && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= 2'b01;
            s_q         <= {16'b0, 15'h7FFF};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dbi_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            mode_q      <= mode_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_dbi_q   <= out_dbi_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_dbi    = out_dbi_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_bow_prbs_dbi_gen.sv
// Scoreboard bench for bow_prbs_dbi_gen: stimulus pushes model words, a negedge monitor checks them.
module tb_bow_prbs_dbi_gen;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;
`ifdef BOW_PRBS_DBI_EN
    localparam bit DBI_ON = 1'b1;
`else
    localparam bit DBI_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             seed_load;
    logic [30:0]      seed;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_dbi;
    logic [CNT_W-1:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH-1:0] model_raw [0:511];
    logic [WIDTH-1:0] dut_raw   [0:511];
    logic [WIDTH-1:0] dut_enc   [0:511];
    int               dut_idx = 0;

    bow_prbs_dbi_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed       (seed),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_dbi    (out_dbi),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poly(input logic [1:0] m, output int l, output int t);
        case (m)
            2'b00:   begin l = 7;  t = 6;  end
            2'b01:   begin l = 15; t = 14; end
            2'b10:   begin l = 23; t = 18; end
            default: begin l = 31; t = 28; end
        endcase
    endtask

    task automatic model_word(input logic [31:0] s_in, input int l, input int t,
                              output logic [WIDTH-1:0] w, output logic [31:0] s_out);
        logic [31:0] s;
        logic [31:0] msk;
        logic        fb;
        msk = (32'h1 << l) - 32'h1;
        s   = s_in;
        w   = '0;
        for (int b = 0; b < WIDTH; b++) begin
            fb = s[l-1] ^ s[t-1];
            w  = {w[WIDTH-2:0], fb};
            s  = ((s << 1) | {31'b0, fb}) & msk;
        end
        s_out = s;
    endtask

    // Rebuild the expected stream from a fresh seed; the first word is DBI-coded against 0
    task automatic gen_seq(input logic [30:0] sd, input logic [1:0] m, input int n);
        int               l, t;
        logic [31:0]      s;
        logic [WIDTH-1:0] w, prev, enc;
        logic             dbi;
        poly(m, l, t);
        s = {1'b0, sd} & ((32'h1 << l) - 32'h1);
        if (s == 32'h0) s = 32'h1;
        prev = '0;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            model_word(s, l, t, w, s);
            model_raw[k] = w;
            dbi = DBI_ON && ($countones(w ^ prev) > WIDTH / 2);
            enc = dbi ? ~w : w;
            prev = enc;
            exp_q.push_back({dbi, enc});
        end
        dut_idx = 0;
    endtask

    task automatic do_load(input logic [30:0] sd, input logic [1:0] m, input logic rdy);
        seed_load = 1'b1;
        seed      = sd;
        mode      = m;
        out_ready = rdy;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        out_ready = 1'b0;
        gen_seq(sd, m, 300);
        check("load_count_cleared", 64'(word_count), 64'd0);
        check("load_valid", 64'(out_valid), 64'd1);
    endtask

    // Monitor: every presented word must match the queue head; a transfer pops it
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got %0h expected a queued word", out_data);
            end else begin
                check("stream_word", 64'({out_dbi, out_data}), 64'(exp_q[0]));
                if (out_ready) begin
                    if (DBI_ON)
                        check("wire_toggles_le_half",
                              64'($countones(out_data ^ (dut_idx == 0 ? '0 : dut_enc[dut_idx-1]))
                                  <= WIDTH / 2), 64'd1);
                    if (dut_idx < 512) begin
                        dut_raw[dut_idx] = out_dbi ? ~out_data : out_data;
                        dut_enc[dut_idx] = out_data;
                    end
                    dut_idx++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] w;
        logic [31:0]      sn;
        logic [30:0]      seed9, seed8;
        int               xfers;
        logic             r;

        reset = 1'b1; seed_load = 1'b0; seed = '0; mode = 2'b00; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_dbi", 64'(out_dbi), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);

        // Default PRBS15 stream from the reset seed
        reset = 1'b0; out_ready = 1'b1;
        gen_seq(31'h7FFF, 2'b01, 300);
        @(posedge clk); #1;
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_word_prbs15", 64'(out_data), 64'h0002);
        check("first_dbi", 64'(out_dbi), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("count_40", 64'(word_count), 64'd40);

        // PRBS7 with zero seed, period and saturation
        do_load(31'h0, 2'b00, 1'b0);
        check("prbs7_word0", 64'(out_data), 64'h0614);
        out_ready = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("count_saturated", 64'(word_count), 64'hFF);
        check("prbs7_repeat_127", 64'(dut_raw[127]), 64'(model_raw[0]));
        check("prbs7_repeat_128", 64'(dut_raw[128]), 64'(model_raw[1]));

        // Random backpressure with a 5-cycle hold
        do_load(31'h1ACE, 2'b01, 1'b0);
        xfers = 0;
        for (int c = 0; c < 100; c++) begin
            r = (c >= 20 && c < 25) ? 1'b0 : 1'($urandom_range(0, 1));
            out_ready = r;
            xfers += int'(r);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        check("count_backpressure", 64'(word_count), 64'(xfers));

        // DBI boundary words chosen from the model
        seed9 = '0; seed8 = '0;
        for (int k = 1; k < 5000; k++) begin
            model_word(32'(k), 15, 14, w, sn);
            if (seed9 == '0 && $countones(w) == 9) seed9 = 31'(k);
            if (seed8 == '0 && $countones(w) == 8) seed8 = 31'(k);
        end
        do_load(seed9, 2'b01, 1'b0);
        check("dbi9_flag", 64'(out_dbi), DBI_ON ? 64'd1 : 64'd0);
        check("dbi9_ones", 64'($countones(out_data)), DBI_ON ? 64'd7 : 64'd9);
        do_load(seed8, 2'b01, 1'b0);
        check("dbi8_flag", 64'(out_dbi), 64'd0);
        check("dbi8_ones", 64'($countones(out_data)), 64'd8);
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        // Seed load coinciding with a transfer
        do_load(31'h12345, 2'b11, 1'b1);
        check("prbs31_word0", 64'(out_data), 64'h0010);
        check("prbs31_dbi0", 64'(out_dbi), 64'd0);
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("count_after_prbs31", 64'(word_count), 64'd20);

        // One-cycle reset mid-stream; a concurrent seed_load must be ignored
        reset = 1'b1; seed_load = 1'b1; seed = 31'h5; mode = 2'b00;
        @(posedge clk); #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", 64'(out_data), 64'd0);
        check("midrst_dbi", 64'(out_dbi), 64'd0);
        check("midrst_count", 64'(word_count), 64'd0);
        reset = 1'b0; seed_load = 1'b0;
        gen_seq(31'h7FFF, 2'b01, 300);
        @(posedge clk); #1;
        check("restart_valid", 64'(out_valid), 64'd1);
        check("restart_word0", 64'(out_data), 64'h0002);
        repeat (40) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("restart_count_40", 64'(word_count), 64'd40);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bow_prbs_dbi_gen.md
Name: bow_prbs_dbi_gen

Overview:
- Parametrised PRBS pattern generator for the BoW link test path.
- Supports selectable standard polynomials (PRBS7/15/23/31) and a seed load.
- Advances WIDTH bits per accepted word and presents words through a valid/ready source interface.
- Applies data-bus-inversion (DBI) against the previously transmitted word to bound wire toggles; sits between the test controller and the lane serializer.

Parameters:
- WIDTH, 16: output word width in bits; even, 8..64.
- CNT_W, 32: width of the accepted-word counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- seed_load  in  1  one-cycle pulse; loads seed and mode, restarts the sequence.
- seed  in  31  seed value; low L bits used.
- mode  in  2  polynomial select, sampled only on seed_load.
- out_valid  out  1  word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WIDTH  encoded word (MSB = first generated bit).
- out_dbi  out  1  1 = out_data is the inverted raw word.
- word_count  out  CNT_W  number of accepted words, saturating.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Polynomial select (L = order, T = second tap):
  - mode 00 = PRBS7, x^7+x^6+1.
  - mode 01 = PRBS15, x^15+x^14+1.
  - mode 10 = PRBS23, x^23+x^18+1.
  - mode 11 = PRBS31, x^31+x^28+1.
- LFSR state s[30:0]; bits at index L and above are held 0.
- One step:
  - fb = s[L-1]^s[T-1].
  - s = {s[L-2:0], fb}.
  - Output bit = fb.
- Raw word = WIDTH successive fb bits, first bit in raw[WIDTH-1]. State advances WIDTH steps per word, combinationally unrolled, in one cycle.
- Seed: s <= seed[L-1:0]. An all-zero seed is replaced by 1 (lock-up avoidance).
- DBI:
  - prev = last word driven on the wire (encoded out_data).
  - If popcount(raw ^ prev) > WIDTH/2, then out_data = ~raw and out_dbi = 1.
  - Otherwise out_data = raw and out_dbi = 0.
  - Exactly WIDTH/2 toggles → no inversion.
- Reset (synchronous):
  - mode_q = 01 (PRBS15), s = all-ones of L bits, prev = 0, word_count = 0.
  - out_valid = 0, out_data = 0, out_dbi = 0.
- Cycle after reset deasserts: out_valid = 1, presenting word 0 of the reset seed.
- Handshake:
  - out_data/out_dbi are registered and held stable while out_valid & !out_ready.
  - On out_valid & out_ready at an edge, the next word is presented in the following cycle. No bubbles; sustained 1 word/clock.
- word_count increments on each transfer and sticks at all-ones.
- seed_load at cycle t:
  - Takes priority over the handshake.
  - A transfer occurring in the same cycle is still counted, then word_count is cleared, so it reads 0 at t+1.
  - mode_q and s load; prev clears to 0.
  - At t+1, out_valid = 1 with word 0 of the new seed.
- seed_load while reset is high is ignored.
- Period: the raw sequence repeats after (2^L - 1) words when gcd(WIDTH, 2^L - 1) = 1.

Optional Feature:
- Macro: BOW_PRBS_DBI_EN.
- Defined: DBI encoding active as above.
- Undefined: out_dbi tied 0, out_data = raw, and the prev register and popcount logic are removed. The generator and handshake are unchanged.

Test Plan:
- Reset then out_ready = 1 for 40 cycles (WIDTH=16, default mode) → out_valid = 1 from the first post-reset cycle. Decoded words (out_dbi ? ~out_data : out_data) match a PRBS15 model seeded 0x7FFF; word_count = 40.
- seed_load with seed = 0, mode = 00 → sequence equals PRBS7 seeded 1. Raw word stream repeats exactly at word 127; word_count cleared to 0 after the load.
- out_ready toggled randomly, including holds of 5 cycles → out_data/out_dbi are unchanged during stalls, and no word is skipped or repeated versus the model.
- DBI check (macro defined) using model-selected raw words:
  - prev = 0x0000, raw with 9 ones → out_dbi = 1, 7 ones on the wire.
  - raw with exactly 8 ones → out_dbi = 0.
  - No wire transition between consecutive words ever exceeds 8 bits.
- seed_load asserted in the same cycle as a transfer, seed = 0x12345, mode = 11:
  - The transfer is counted and then cleared (word_count = 0 at t+1).
  - The next word is word 0 of PRBS31 from 0x12345, with prev = 0.
- Reset asserted mid-stream for 1 cycle → all outputs return to reset values that cycle, and the stream restarts identically to the first test.
